fetch_unit: RTL

Instruction fetch stage for the FyraVortex RV32I core; sits directly upstream of the decode controller. Maintains the program counter and issues word requests to instruction memory over a request/grant/response interface. Buffers returned instructions with their PCs and presents one instruction per cycle to decode, pre-split into the opcode/f3/f7 fields the controller consumes. Accepts stall from decode and PC redirects from branch/jump resolution.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage for the FyraVortex RV32I core.
// Keeps the PC, issues word requests to instruction memory, buffers the
// returned words with their PCs and hands one instruction per cycle to decode.
//
// Memory handshake: a request transfers on a cycle where imem_req and
// imem_gnt are both high; imem_addr is held until that happens. Responses
// come back one per imem_rvalid cycle, in grant order, no earlier than the
// cycle after the grant. Toward decode an instruction is consumed on any
// cycle with inst_valid high and stall low.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  f3,
  output logic [6:0]  f7
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetchPc;
  logic          started;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  // pending-PC queue: PCs of granted requests still awaiting a response
  logic [31:0]   pendPc [BUF_DEPTH];
  logic [PW-1:0] pendWr;
  logic [PW-1:0] pendRd;

  // instruction buffer: {pc, inst} pairs waiting for decode
  logic [31:0]   bufPc   [BUF_DEPTH];
  logic [31:0]   bufInst [BUF_DEPTH];
  logic [PW-1:0] bufWr;
  logic [PW-1:0] bufRd;
  logic [CW-1:0] bufCount;

  logic          pop;
  logic          grant;
  logic          bufPush;
  logic [OW-1:0] occupancy;
  logic          unusedBits;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // low target bits are forced to zero, so they are intentionally dropped
  assign unusedBits = ^redirect_pc[1:0];

  assign inst_valid = (bufCount != '0);
  assign inst       = inst_valid ? bufInst[bufRd] : NOP;
  assign inst_pc    = inst_valid ? bufPc[bufRd]   : 32'h0;
  assign opcode     = inst[6:0];
  assign f3         = inst[14:12];
  assign f7         = inst[31:25];

  // request only while a slot (buffer entry or in-flight) is free after this cycle's pop
  always_comb begin
    pop       = inst_valid & ~stall;
    occupancy = OW'(outstanding) + OW'(bufCount) - OW'(pop);
    imem_req  = started & ~redirect & (occupancy < OW'(BUF_DEPTH));
    imem_addr = fetchPc;
    grant     = imem_req & imem_gnt;
    bufPush   = imem_rvalid & ~redirect & (discard == '0);
  end

  // control state: PC, counters, queue pointers; redirect flushes and overrides stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      fetchPc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      pendWr      <= '0;
      pendRd      <= '0;
      bufWr       <= '0;
      bufRd       <= '0;
      bufCount    <= '0;
    end else begin
      started <= 1'b1;
      // every response retires its pending PC, even when the data is dropped
      if (imem_rvalid) pendRd <= nextPtr(pendRd);
      if (redirect) begin
        fetchPc     <= {redirect_pc[31:2], 2'b00};
        outstanding <= outstanding - CW'(imem_rvalid);
        discard     <= outstanding - CW'(imem_rvalid);
        bufWr       <= '0;
        bufRd       <= '0;
        bufCount    <= '0;
      end else begin
        if (grant) begin
          pendWr  <= nextPtr(pendWr);
          fetchPc <= fetchPc + 32'd4;
        end
        outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
        if (imem_rvalid && (discard != '0)) discard <= discard - CW'(1);
        if (bufPush) bufWr <= nextPtr(bufWr);
        if (pop) bufRd <= nextPtr(bufRd);
        bufCount <= bufCount + CW'(bufPush) - CW'(pop);
      end
    end
  end

  // queue storage: validity is tracked by the pointers/counters above
  always_ff @(posedge clk) begin
    if (grant) pendPc[pendWr] <= fetchPc;
    if (bufPush) begin
      bufPc[bufWr]   <= pendPc[pendRd];
      bufInst[bufWr] <= imem_rdata;
    end
  end

endmodule
